// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue unit: opcodes, FSM states, widths.
package alu_issue_pkg;

  localparam int OPND_W = 8;
  localparam int SEL_W  = 4;
  localparam int RES_W  = 16;
  localparam int CMD_W  = SEL_W + 2 * OPND_W;

  localparam logic [SEL_W-1:0] OP_AND       = 4'b0000;
  localparam logic [SEL_W-1:0] OP_OR        = 4'b0001;
  localparam logic [SEL_W-1:0] OP_XOR       = 4'b0010;
  localparam logic [SEL_W-1:0] OP_XNOR      = 4'b0011;
  localparam logic [SEL_W-1:0] OP_NAND      = 4'b0100;
  localparam logic [SEL_W-1:0] OP_NOTA_OR_B = 4'b0101;
  localparam logic [SEL_W-1:0] OP_ADD       = 4'b0110;
  localparam logic [SEL_W-1:0] OP_SUB       = 4'b0111;
  localparam logic [SEL_W-1:0] OP_DIV       = 4'b1000;
  localparam logic [SEL_W-1:0] OP_CONCAT    = 4'b1001;
  localparam logic [SEL_W-1:0] OP_REPL      = 4'b1010;
  localparam logic [SEL_W-1:0] OP_SHLA      = 4'b1011;
  localparam logic [SEL_W-1:0] OP_SHRA      = 4'b1100;
  localparam logic [SEL_W-1:0] OP_SHLB      = 4'b1101;
  localparam logic [SEL_W-1:0] OP_SHRB      = 4'b1110;
  localparam logic [SEL_W-1:0] OP_REDOR_B   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue unit; DEPTH must be a power of two so the
// pointers wrap naturally. No bypass: a written entry is readable next cycle.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Queues ALU commands, issues them to an external combinational ALU and holds
// each result until consumed. Optional divide-by-zero override: ALU_ISSUE_DIVZ_EN.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic [SEL_W-1:0]  rsp_sel,
  output logic              rsp_divz,
  output logic              busy
);

  state_t            state_q, state_d;
  logic              fifo_full, fifo_empty;
  logic [CMD_W-1:0]  fifo_rdata;
  logic              pop, load, capture;
  logic              divz_hit;
  logic [RES_W-1:0]  cap_data;

  logic [OPND_W-1:0] alu_a_q, alu_b_q;
  logic [SEL_W-1:0]  alu_sel_q;
  logic [RES_W-1:0]  rsp_data_q;
  logic [SEL_W-1:0]  rsp_sel_q;
  logic              rsp_divz_q;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && cmd_ready),
    .wdata_i ({cmd_sel, cmd_a, cmd_b}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_ready = !fifo_full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ALU_ISSUE_DIVZ_EN
  assign divz_hit = (alu_sel_q == OP_DIV) && (alu_b_q == '0);
`else
  assign divz_hit = 1'b0;
`endif

  assign cap_data = divz_hit ? {RES_W{1'b1}} : alu_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      rsp_data_q <= '0;
      rsp_sel_q  <= '0;
      rsp_divz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        {alu_sel_q, alu_a_q, alu_b_q} <= fifo_rdata;
      end
      // Response registers change only here, so they hold through RESP.
      if (capture) begin
        rsp_data_q <= cap_data;
        rsp_sel_q  <= alu_sel_q;
        rsp_divz_q <= divz_hit;
      end
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_sel   = rsp_sel_q;
  assign rsp_divz  = rsp_divz_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU on the issue port.
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic [3:0]  cmd_sel = '0;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_sel;
  logic        rsp_divz;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  va [12];
  logic [7:0]  vb [12];
  logic [3:0]  vs [12];
  logic [15:0] vexp [12];
  logic [15:0] got_data [16];
  logic [3:0]  got_sel [16];
  int          got_cyc [16];

  alu_issue_unit #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_sel   (rsp_sel),
    .rsp_divz  (rsp_divz),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] s);
    case (s)
      OP_AND:       return {8'h00, a & b};
      OP_OR:        return {8'h00, a | b};
      OP_XOR:       return {8'h00, a ^ b};
      OP_XNOR:      return {8'h00, ~(a ^ b)};
      OP_NAND:      return {8'h00, ~(a & b)};
      OP_NOTA_OR_B: return {8'h00, (~a) | b};
      OP_ADD:       return {8'h00, a} + {8'h00, b};
      OP_SUB:       return {8'h00, a} - {8'h00, b};
      OP_DIV:       return (b == 8'h00) ? 16'h0000 : {8'h00, a / b};
      OP_CONCAT:    return {a, b};
      OP_REPL:      return {a, a};
      OP_SHLA:      return {7'b0, a, 1'b0};
      OP_SHRA:      return {9'b0, a[7:1]};
      OP_SHLB:      return {7'b0, b, 1'b0};
      OP_SHRB:      return {9'b0, b[7:1]};
      default:      return {15'b0, |b};
    endcase
  endfunction

  assign alu_out = alu_model(alu_a, alu_b, alu_sel);

  task automatic init_vectors();
    va[0]  = 8'h0F; vb[0]  = 8'h33; vs[0]  = OP_AND;       vexp[0]  = 16'h0003;
    va[1]  = 8'h0F; vb[1]  = 8'h33; vs[1]  = OP_OR;        vexp[1]  = 16'h003F;
    va[2]  = 8'h0F; vb[2]  = 8'h33; vs[2]  = OP_XOR;       vexp[2]  = 16'h003C;
    va[3]  = 8'h0F; vb[3]  = 8'h33; vs[3]  = OP_XNOR;      vexp[3]  = 16'h00C3;
    va[4]  = 8'h0F; vb[4]  = 8'h33; vs[4]  = OP_NAND;      vexp[4]  = 16'h00FC;
    va[5]  = 8'h0F; vb[5]  = 8'h33; vs[5]  = OP_NOTA_OR_B; vexp[5]  = 16'h00F3;
    va[6]  = 8'hC8; vb[6]  = 8'h64; vs[6]  = OP_ADD;       vexp[6]  = 16'h012C;
    va[7]  = 8'h05; vb[7]  = 8'h07; vs[7]  = OP_SUB;       vexp[7]  = 16'hFFFE;
    va[8]  = 8'h64; vb[8]  = 8'h07; vs[8]  = OP_DIV;       vexp[8]  = 16'h000E;
    va[9]  = 8'h12; vb[9]  = 8'h34; vs[9]  = OP_REPL;      vexp[9]  = 16'h1212;
    va[10] = 8'h81; vb[10] = 8'h00; vs[10] = OP_SHLA;      vexp[10] = 16'h0102;
    va[11] = 8'h81; vb[11] = 8'h00; vs[11] = OP_SHRA;      vexp[11] = 16'h0040;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one command until accepted; returns at accept edge + 1.
  task automatic push_vec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                          output bit ok);
    int budget;
    budget = 40;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = s;
    while (!ok && budget > 0) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept got timeout exp accepted (sel %h)", s);
    end
  endtask

  task automatic collect(input int n, input int budget, output int got);
    int left;
    left = budget;
    got = 0;
    while (got < n && left > 0) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        got_data[got] = rsp_data;
        got_sel[got]  = rsp_sel;
        got_cyc[got]  = cyc;
        got++;
      end
      left--;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, busy, rsp_divz, rsp_data, rsp_sel, alu_a, alu_b, alu_sel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0",
               {rsp_valid, busy, rsp_divz, rsp_data, rsp_sel, alu_a, alu_b, alu_sel});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL post_reset_idle got %b exp 001", {rsp_valid, busy, cmd_ready});
    end
  endtask

  // The accept edge is counted as edge 1: pop on edge 2, rsp_valid from edge 3.
  task automatic test_single();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 8'd42; cmd_b = 8'd240; cmd_sel = OP_ADD;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready got %b exp 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, alu_a, alu_b, alu_sel, busy} !== {1'b0, 8'd42, 8'd240, OP_ADD, 1'b1}) begin
      errors++;
      $display("FAIL single_issue got v=%b a=%0d b=%0d sel=%h busy=%b exp v=0 a=42 b=240 sel=6 busy=1",
               rsp_valid, alu_a, alu_b, alu_sel, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_sel} !== {1'b1, 16'd282, OP_ADD}) begin
      errors++;
      $display("FAIL single_rsp got v=%b data=%0d sel=%h exp v=1 data=282 sel=6",
               rsp_valid, rsp_data, rsp_sel);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL single_done got %b exp 00", {rsp_valid, busy});
    end
    checks++;
    if ({alu_a, alu_sel} !== {8'd42, OP_ADD}) begin
      errors++; $display("FAIL alu_hold got %h exp %h", {alu_a, alu_sel}, {8'd42, OP_ADD});
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int got;
    rsp_ready = 1'b1;
    fork
      begin
        push_vec(8'd42, 8'd240, OP_CONCAT, ok1);
        push_vec(8'd42, 8'd240, OP_AND, ok2);
      end
      collect(2, 40, got);
    join
    checks++;
    if (got !== 2) begin
      errors++; $display("FAIL b2b_count got %0d exp 2", got);
    end else begin
      checks++;
      if ({got_data[0], got_sel[0]} !== {16'd10992, OP_CONCAT}) begin
        errors++; $display("FAIL b2b_first got %0d/%h exp 10992/9", got_data[0], got_sel[0]);
      end
      checks++;
      if ({got_data[1], got_sel[1]} !== {16'd32, OP_AND}) begin
        errors++; $display("FAIL b2b_second got %0d/%h exp 32/0", got_data[1], got_sel[1]);
      end
      checks++;
      if (got_cyc[1] - got_cyc[0] !== 2) begin
        errors++; $display("FAIL b2b_spacing got %0d exp 2", got_cyc[1] - got_cyc[0]);
      end
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    int acc;
    int got;
    bit r;
    bit last_r;
    rsp_ready = 1'b0;
    acc = 0;
    last_r = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cmd_valid = 1'b1; cmd_a = va[k]; cmd_b = vb[k]; cmd_sel = vs[k];
      @(negedge clk);
      r = cmd_ready;
      if (r) acc++;
      last_r = r;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (acc !== 5) begin
      errors++; $display("FAIL bp_accepted got %0d exp 5", acc);
    end
    checks++;
    if (last_r !== 1'b0) begin
      errors++; $display("FAIL bp_sixth_refused got ready=%b exp 0", last_r);
    end
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, vexp[0]}) begin
      errors++; $display("FAIL bp_first_rsp got %b/%h exp 1/%h", rsp_valid, rsp_data, vexp[0]);
    end
    idle(4);
    checks++;
    if ({rsp_valid, rsp_data, rsp_sel, cmd_ready} !== {1'b1, vexp[0], vs[0], 1'b0}) begin
      errors++;
      $display("FAIL bp_hold got v=%b data=%h sel=%h rdy=%b exp v=1 data=%h sel=%h rdy=0",
               rsp_valid, rsp_data, rsp_sel, cmd_ready, vexp[0], vs[0]);
    end
    rsp_ready = 1'b1;
    collect(5, 40, got);
    checks++;
    if (got !== 5) begin
      errors++; $display("FAIL bp_drain_count got %0d exp 5", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (got_data[i] !== vexp[i]) begin
        errors++; $display("FAIL bp_drain[%0d] got %h exp %h", i, got_data[i], vexp[i]);
      end
    end
    idle(3);
  endtask

  task automatic wait_rsp(output bit seen);
    int budget;
    budget = 10;
    seen = rsp_valid;
    while (!seen && budget > 0) begin
      @(posedge clk);
      #1;
      seen = rsp_valid;
      budget--;
    end
  endtask

  task automatic test_divz();
    bit ok;
    bit seen;
    logic [16:0] exp_z;
`ifdef ALU_ISSUE_DIVZ_EN
    exp_z = {1'b1, 16'hFFFF};
`else
    exp_z = {1'b0, 16'h0000};
`endif
    rsp_ready = 1'b1;
    push_vec(8'd42, 8'd0, OP_DIV, ok);
    wait_rsp(seen);
    checks++;
    if ({seen, rsp_divz, rsp_data} !== {1'b1, exp_z}) begin
      errors++;
      $display("FAIL divz_zero got v=%b divz=%b data=%h exp v=1 divz/data=%h",
               seen, rsp_divz, rsp_data, exp_z);
    end
    idle(2);
    push_vec(8'd100, 8'd7, OP_DIV, ok);
    wait_rsp(seen);
    checks++;
    if ({seen, rsp_divz, rsp_data} !== {1'b1, 1'b0, 16'd14}) begin
      errors++;
      $display("FAIL divz_nonzero got v=%b divz=%b data=%h exp v=1 divz=0 data=000e",
               seen, rsp_divz, rsp_data);
    end
    idle(3);
  endtask

  task automatic test_reset_midop();
    bit ok;
    bit seen;
    rsp_ready = 1'b0;
    for (int k = 6; k < 10; k++) push_vec(va[k], vb[k], vs[k], ok);
    wait_rsp(seen);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy, alu_a} !== {1'b0, 1'b1, va[7]}) begin
      errors++;
      $display("FAIL rstmid_pre got v=%b busy=%b a=%h exp v=0 busy=1 a=%h",
               rsp_valid, busy, alu_a, va[7]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, busy, rsp_divz, rsp_data, rsp_sel, alu_a, alu_b, alu_sel} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h exp 0",
               {rsp_valid, busy, rsp_divz, rsp_data, rsp_sel, alu_a, alu_b, alu_sel});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %b exp 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_rsp got activity=%b exp 0", seen);
    end
    push_vec(8'd42, 8'd240, OP_REDOR_B, ok);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_early got %b exp 0", rsp_valid);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_sel} !== {1'b1, 16'd1, OP_REDOR_B}) begin
      errors++;
      $display("FAIL rstmid_fresh got v=%b data=%h sel=%h exp v=1 data=0001 sel=f",
               rsp_valid, rsp_data, rsp_sel);
    end
    idle(3);
  endtask

  task automatic test_wrap();
    bit ok;
    int got;
    rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) push_vec(va[i], vb[i], vs[i], ok);
      end
      collect(12, 200, got);
    join
    checks++;
    if (got !== 12) begin
      errors++; $display("FAIL wrap_count got %0d exp 12", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if ({got_data[i], got_sel[i]} !== {vexp[i], vs[i]}) begin
        errors++;
        $display("FAIL wrap[%0d] got %h/%h exp %h/%h", i, got_data[i], got_sel[i], vexp[i], vs[i]);
      end
    end
    idle(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wrap_idle got busy=%b exp 0", busy);
    end
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_divz();
    test_reset_midop();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 The block SHALL have exactly one parameter: FIFO_DEPTH, default 4, command FIFO depth (power of two, at least 2).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO can accept
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_sel  in  4  ALU opcode
alu_a  out  8  registered operand A to external combinational ALU
alu_b  out  8  registered operand B to ALU
alu_sel  out  4  registered opcode to ALU
alu_out  in  16  ALU result
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_data  out  16  captured result
rsp_sel  out  4  opcode tag of the response
rsp_divz  out  1  divide-by-zero flag
busy  out  1  FSM not IDLE, or FIFO not empty

Function
REQ-003 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high.
REQ-004 cmd_ready SHALL equal the inverse of FIFO-full; a pop in the same cycle SHALL NOT raise cmd_ready while full.
REQ-005 The FIFO SHALL be first-in first-out; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-006 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-007 There SHALL be no empty-FIFO bypass: an accepted command becomes poppable on the following cycle.
REQ-008 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-009 In IDLE with the FIFO not empty, the next edge SHALL pop one entry, load alu_a, alu_b and alu_sel, and move to ISSUE.
REQ-010 In ISSUE, the next edge SHALL capture alu_out into rsp_data and alu_sel into rsp_sel, and move to RESP.
REQ-011 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_sel and rsp_divz SHALL hold stable until rsp_ready is 1.
REQ-012 On the RESP handshake edge, the FSM SHALL pop the next entry and go to ISSUE if the FIFO is not empty, otherwise go to IDLE.
REQ-013 Latency SHALL be fixed: rsp_valid rises 2 edges after the edge that pops the command; on an idle block with an empty FIFO, this is 3 edges after the accept edge.
REQ-014 Sustained throughput SHALL be one result per 2 cycles while rsp_ready is held high.
REQ-015 alu_a, alu_b and alu_sel SHALL hold their last issued values outside ISSUE.
REQ-016 rsp_data SHALL be alu_out unmodified (full 16 bits), except as stated in REQ-020.
REQ-017 busy SHALL be 1 whenever the state is not IDLE or the FIFO is not empty.

Reset
REQ-018 While rst is high, the block SHALL asynchronously force the state to IDLE, empty the FIFO, drive cmd_ready=1, and drive all other outputs to 0.
REQ-019 An assertion of rst mid-operation SHALL discard the in-flight command and every queued command, with no response produced; after release, the first accepted command SHALL behave as on a fresh block.

Configuration
REQ-020 With ALU_ISSUE_DIVZ_EN defined, the block SHALL apply a divide-by-zero override when capturing an opcode 4'b1000 issue with alu_b==0:
- rsp_divz=1 and rsp_data=16'hFFFF, regardless of alu_out;
- otherwise rsp_divz=0.
REQ-021 Without ALU_ISSUE_DIVZ_EN, rsp_divz SHALL be constant 0 and rsp_data SHALL always be alu_out.

Structure
REQ-022 A shared package alu_issue_pkg SHALL hold:
- the opcode constants (AND 0000, OR 0001, XOR 0010, XNOR 0011, NAND 0100, NOTA_OR_B 0101, ADD 0110, SUB 0111, DIV 1000, CONCAT 1001, REPL 1010, SHLA 1011, SHRA 1100, SHLB 1101, SHRB 1110, REDOR_B 1111);
- the state typedef;
- the width constants 8, 4 and 16.
REQ-023 The FIFO SHALL be a sub-module named alu_cmd_fifo, 20 bits wide ({sel,a,b}) and FIFO_DEPTH entries deep; the FSM and capture logic SHALL stay in alu_issue_unit.

Verification
REQ-024 The bench SHALL pair the block with a behavioural ALU using the opcodes in REQ-022 and SHALL cover:
- Single op: a=42, b=240, sel=0110, rsp_ready=1 -> rsp_data=282 and rsp_sel=0110, with rsp_valid rising 3 edges after the accept edge.
- Back-to-back: sel 1001 then 0000 with a=42, b=240 -> responses 10992 then 32, in order, 2 cycles apart.
- Backpressure: rsp_ready=0 while offering 6 commands -> 5 accepted (1 in flight + 4 queued), 6th refused with cmd_ready=0, rsp_data held stable; on release all 5 drain in order.
- Divide by zero with ALU_ISSUE_DIVZ_EN: a=42, b=0, sel=1000 -> rsp_divz=1, rsp_data=16'hFFFF; without the macro -> rsp_divz=0 and rsp_data equals the ALU model output.
- Reset mid-op: rst pulsed while in ISSUE with 2 commands queued -> all outputs 0, cmd_ready=1, busy=0, no response; a subsequent a=42, b=240, sel=1111 -> rsp_data=1.
- Wrap-around: 3*FIFO_DEPTH sequential commands with rsp_ready=1 -> every result correct and in order across pointer wraps.
